// File: rtl/ring_sequence_monitor_pkg.sv
// Shared types and helpers for the ring-counter sequence monitor.
// Contents: FSM state enum, one-hot decode result struct, index-width helper,
//           circular rotate-left and one-hot index functions.
// Functions operate on MAX_W-bit words; callers zero-extend their ring word
// and pass the real ring width where the function needs it.
package ring_pkg;

    localparam int unsigned MAX_W     = 64;
    localparam int unsigned MAX_IDX_W = 6;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    typedef struct packed {
        logic                 is_onehot;
        logic [MAX_IDX_W-1:0] idx;
    } onehot_idx_t;

    // Bits needed to hold an index into a word of width w.
    function automatic int unsigned idx_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Circular rotate-left of the low 'width' bits; bits above width come back zero.
    function automatic logic [MAX_W-1:0] rot_left(input logic [MAX_W-1:0] word,
                                                  input int unsigned      width);
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - width);
        return ((word << 1) | (word >> (width - 1))) & mask;
    endfunction

    // Index of the highest set bit plus a flag telling whether exactly one bit is set.
    function automatic onehot_idx_t onehot_idx(input logic [MAX_W-1:0] word);
        onehot_idx_t res;
        res.is_onehot = (word != '0) && ((word & (word - MAX_W'(1))) == '0);
        res.idx       = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (word[i]) res.idx = MAX_IDX_W'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/ring_sequence_monitor_if.sv
// Bus between a ring-word source and the sequence monitor.
// master: drives ring_in/in_valid, observes monitor status.
// slave : the monitor; samples ring_in/in_valid, drives phase/phase_valid,
//         locked, err, err_count, rot_count.
interface ring_sequence_monitor_if
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8,
    parameter int unsigned ROT_CNT_W = 16
);
    localparam int unsigned PHASE_W = idx_w(WIDTH);

    logic [WIDTH-1:0]     ring_in;
    logic                 in_valid;
    logic [PHASE_W-1:0]   phase;
    logic                 phase_valid;
    logic                 locked;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;
    logic [ROT_CNT_W-1:0] rot_count;

    modport master (
        output ring_in, in_valid,
        input  phase, phase_valid, locked, err, err_count, rot_count
    );

    modport slave (
        input  ring_in, in_valid,
        output phase, phase_valid, locked, err, err_count, rot_count
    );

endinterface

// File: rtl/ring_sequence_monitor_decode.sv
// Combinational one-hot decoder for the sampled ring word.
// Ports: word_i (ring word), is_onehot_o (exactly one bit set),
//        idx_o (binary index of the set bit, meaningful when is_onehot_o).
module ring_onehot_decode
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]        word_i,
    output logic                    is_onehot_o,
    output logic [idx_w(WIDTH)-1:0] idx_o
);
    localparam int unsigned IDX_W = idx_w(WIDTH);

    onehot_idx_t dec_c;

    always_comb begin
        dec_c = onehot_idx(MAX_W'(word_i));
    end

    // A zero-extended one-hot word always yields an index that fits IDX_W;
    // the upper-bit guard just makes that explicit.
    assign is_onehot_o = dec_c.is_onehot && ((dec_c.idx >> IDX_W) == '0);
    assign idx_o       = IDX_W'(dec_c.idx);

endmodule

// File: rtl/ring_sequence_monitor.sv
// Receive-side checker for a left-rotating one-hot ring-counter stream.
// Ports: clk, rst (sync, active-high), bus (slave modport):
//   ring_in/in_valid in; phase/phase_valid, locked, err, err_count (saturating),
//   rot_count (wrapping, counts returns to the MSB pattern while locked) out.
// Acquires lock after LOCK_CNT consecutive in-order one-hot samples, then
// tracks phase and drops to HUNT on the first out-of-order sample.
module ring_sequence_monitor
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned ERR_CNT_W = 8,
    parameter int unsigned ROT_CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    ring_sequence_monitor_if.slave bus
);
    localparam int unsigned PHASE_W = idx_w(WIDTH);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);

    ring_state_e          state_q;
    logic [WIDTH-1:0]     last_q;
    logic [MATCH_W-1:0]   match_q;
    logic [PHASE_W-1:0]   phase_q;
    logic                 phase_valid_q;
    logic                 locked_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ROT_CNT_W-1:0] rot_cnt_q;

    logic                 is_onehot_c;
    logic [PHASE_W-1:0]   idx_c;
    logic [WIDTH-1:0]     expected_c;
    logic                 in_order_c;
    logic [MATCH_W-1:0]   match_inc_c;

    ring_onehot_decode #(.WIDTH(WIDTH)) u_decode (
        .word_i      (bus.ring_in),
        .is_onehot_o (is_onehot_c),
        .idx_o       (idx_c)
    );

    // Next word the ring must present if the previous one was accepted.
    assign expected_c  = WIDTH'(rot_left(MAX_W'(last_q), WIDTH));
    assign in_order_c  = (bus.ring_in == expected_c);
    assign match_inc_c = match_q + MATCH_W'(1);

    // Acquisition / tracking FSM with its counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            last_q        <= '0;
            match_q       <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
            rot_cnt_q     <= '0;
        end else begin
            phase_valid_q <= 1'b0;
            err_q         <= 1'b0;
            if (bus.in_valid) begin
                case (state_q)
                    HUNT: begin
                        if (is_onehot_c) begin
                            last_q  <= bus.ring_in;
                            match_q <= MATCH_W'(1);
                            state_q <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (in_order_c) begin
                            last_q  <= bus.ring_in;
                            match_q <= match_inc_c;
                            if (match_inc_c == MATCH_W'(LOCK_CNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (is_onehot_c) begin
                            // Valid but out-of-order word: start counting again from it.
                            last_q  <= bus.ring_in;
                            match_q <= MATCH_W'(1);
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (in_order_c) begin
                            last_q        <= bus.ring_in;
                            phase_q       <= idx_c;
                            phase_valid_q <= 1'b1;
                            if (bus.ring_in[WIDTH-1]) rot_cnt_q <= rot_cnt_q + ROT_CNT_W'(1);
                        end else begin
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
                            state_q  <= HUNT;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.locked      = locked_q;
    assign bus.err         = err_q;
    assign bus.err_count   = err_cnt_q;
    assign bus.rot_count   = rot_cnt_q;

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Bench for ring_sequence_monitor: two instances (8-bit and 2-bit error
// counters) share one stimulus stream and are compared every cycle against a
// run-length/position model, with literal spot checks along the way.
module tb_ring_sequence_monitor;

    localparam int unsigned W    = 4;
    localparam int unsigned LOCK = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] ring_in = '0;
    logic         in_valid = 1'b0;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    ring_sequence_monitor_if #(.WIDTH(W), .ERR_CNT_W(8), .ROT_CNT_W(16)) bus_a ();
    ring_sequence_monitor_if #(.WIDTH(W), .ERR_CNT_W(2), .ROT_CNT_W(16)) bus_b ();

    assign bus_a.ring_in  = ring_in;
    assign bus_a.in_valid = in_valid;
    assign bus_b.ring_in  = ring_in;
    assign bus_b.in_valid = in_valid;

    ring_sequence_monitor #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(8), .ROT_CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ring_sequence_monitor #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(2), .ROT_CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Model: run = length of the current in-order one-hot run (0 = hunting),
    // pos_last = bit position of the last accepted word.
    int m_run, m_last, m_phase, m_errc, m_errc2, m_rot;
    bit m_locked, m_pv, m_err;

    initial begin
        m_run = 0; m_last = 0; m_phase = 0; m_errc = 0; m_errc2 = 0; m_rot = 0;
        m_locked = 0; m_pv = 0; m_err = 0;
    end

    always @(posedge clk) begin : model
        int pos;
        m_pv  = 0;
        m_err = 0;
        if (rst) begin
            m_run = 0; m_last = 0; m_phase = 0; m_errc = 0; m_errc2 = 0; m_rot = 0;
            m_locked = 0;
        end else if (in_valid) begin
            pos = ($countones(ring_in) == 1) ? $clog2(ring_in) : -1;
            if (m_locked) begin
                if (pos == (m_last + 1) % W) begin
                    m_last  = pos;
                    m_phase = pos;
                    m_pv    = 1;
                    if (pos == W - 1) m_rot = (m_rot + 1) % 65536;
                end else begin
                    m_err    = 1;
                    m_errc   = (m_errc  < 255) ? m_errc  + 1 : 255;
                    m_errc2  = (m_errc2 < 3)   ? m_errc2 + 1 : 3;
                    m_locked = 0;
                    m_run    = 0;
                end
            end else if (m_run > 0 && pos == (m_last + 1) % W) begin
                m_run++;
                m_last = pos;
                if (m_run == LOCK) m_locked = 1;
            end else if (pos >= 0) begin
                m_run  = 1;
                m_last = pos;
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            cmp("a_phase",       32'(bus_a.phase),       32'(m_phase));
            cmp("a_phase_valid", 32'(bus_a.phase_valid), 32'(m_pv));
            cmp("a_locked",      32'(bus_a.locked),      32'(m_locked));
            cmp("a_err",         32'(bus_a.err),         32'(m_err));
            cmp("a_err_count",   32'(bus_a.err_count),   32'(m_errc));
            cmp("a_rot_count",   32'(bus_a.rot_count),   32'(m_rot));
            cmp("b_phase",       32'(bus_b.phase),       32'(m_phase));
            cmp("b_phase_valid", 32'(bus_b.phase_valid), 32'(m_pv));
            cmp("b_locked",      32'(bus_b.locked),      32'(m_locked));
            cmp("b_err",         32'(bus_b.err),         32'(m_err));
            cmp("b_err_count",   32'(bus_b.err_count),   32'(m_errc2));
            cmp("b_rot_count",   32'(bus_b.rot_count),   32'(m_rot));
        end
    end

    // Drive one sample, then return just after the edge that consumed it.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        ring_in  = d;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] rc;
    logic [W-1:0] fv [5];

    initial begin
        fv = '{4'b1111, 4'b0000, 4'b1000, 4'b0010, 4'b0110};

        // Reset
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        armed = 1'b1;
        cmp("rst_locked",    32'(bus_a.locked),    32'd0);
        cmp("rst_err_count", 32'(bus_a.err_count), 32'd0);
        cmp("rst_rot_count", 32'(bus_a.rot_count), 32'd0);
        cmp("rst_phase",     32'(bus_a.phase),     32'd0);

        // Lock-up
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0010);
        cmp("lock_not_yet",  32'(bus_a.locked),      32'd0);
        step(1'b0, 1'b1, 4'b0100);
        cmp("lock_locked",   32'(bus_a.locked),      32'd1);
        cmp("lock_no_pv",    32'(bus_a.phase_valid), 32'd0);

        // Tracking
        step(1'b0, 1'b1, 4'b1000);
        cmp("trk_phase3",    32'(bus_a.phase),       32'd3);
        cmp("trk_pv3",       32'(bus_a.phase_valid), 32'd1);
        cmp("trk_rot1",      32'(bus_a.rot_count),   32'd1);
        step(1'b0, 1'b1, 4'b0001);
        cmp("trk_phase0",    32'(bus_a.phase),       32'd0);
        cmp("trk_pv0",       32'(bus_a.phase_valid), 32'd1);

        // Fault: multi-hot while expecting 0010
        step(1'b0, 1'b1, 4'b0110);
        cmp("flt_err",       32'(bus_a.err),       32'd1);
        cmp("flt_err_count", 32'(bus_a.err_count), 32'd1);
        cmp("flt_unlocked",  32'(bus_a.locked),    32'd0);
        step(1'b0, 1'b1, 4'b1000);
        cmp("flt_err_pulse", 32'(bus_a.err),       32'd0);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0010);
        step(1'b0, 1'b1, 4'b0100);
        cmp("flt_relock",    32'(bus_a.locked),    32'd1);

        // Stall mid-lock
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'b0110);
            cmp("stall_pv",     32'(bus_a.phase_valid), 32'd0);
            cmp("stall_err",    32'(bus_a.err),         32'd0);
            cmp("stall_locked", 32'(bus_a.locked),      32'd1);
        end
        cmp("stall_phase",   32'(bus_a.phase),     32'd0);
        cmp("stall_rot",     32'(bus_a.rot_count), 32'd1);
        step(1'b0, 1'b1, 4'b1000);
        cmp("resume_phase",  32'(bus_a.phase),     32'd3);
        cmp("resume_rot",    32'(bus_a.rot_count), 32'd2);

        // Zero word faults, then restart inside VERIFY
        step(1'b0, 1'b1, 4'b0000);
        cmp("zero_err_count", 32'(bus_a.err_count), 32'd2);
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0100);
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b0001);
        cmp("restart_not_locked", 32'(bus_a.locked), 32'd0);
        step(1'b0, 1'b1, 4'b0010);
        cmp("restart_locked",     32'(bus_a.locked), 32'd1);

        // Saturation: five different faults, each followed by a relock
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, fv[i]);
            cmp("sat_err",      32'(bus_a.err),    32'd1);
            cmp("sat_unlocked", 32'(bus_a.locked), 32'd0);
            step(1'b0, 1'b1, 4'b0001);
            step(1'b0, 1'b1, 4'b0010);
            step(1'b0, 1'b1, 4'b0100);
            step(1'b0, 1'b1, 4'b1000);
        end
        cmp("sat_err_count_a", 32'(bus_a.err_count), 32'd7);
        cmp("sat_err_count_b", 32'(bus_b.err_count), 32'd3);

        // Reset while locked with an in-order sample present
        step(1'b1, 1'b1, 4'b0001);
        cmp("rst_mid_err",    32'(bus_a.err),       32'd0);
        cmp("rst_mid_locked", 32'(bus_a.locked),    32'd0);
        cmp("rst_mid_errc",   32'(bus_a.err_count), 32'd0);
        cmp("rst_mid_rot",    32'(bus_a.rot_count), 32'd0);

        // Back-to-back ring counter
        rc = 4'b1000;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, rc);
            rc = {rc[W-2:0], rc[W-1]};
        end
        cmp("b2b_locked", 32'(bus_a.locked),    32'd1);
        cmp("b2b_rot",    32'(bus_a.rot_count), 32'd9);
        cmp("b2b_errc",   32'(bus_a.err_count), 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
